conversor_bin_bcd_8bits: RTL
============================

// Module: conversor_bin_bcd_8bits
// PURPOSE
//   Sequential binary-to-BCD converter (shift-add-3, one bit per clock) placed
//   directly downstream of the ULA 8-to-1 result mux. Captures the mux 8-bit
//   output Y on a start request and produces decimal digits, sign and zero
//   flags for the display decoders. Results are held stable until the next conversion.
// PARAMETERS
//   WIDTH   8  binary input width; also the number of shift cycles per conversion
//   DIGITS  3  BCD digits produced; DIGITS*4 >= bits needed for 2**WIDTH-1
// PORTS
//   clk          in   1          rising-edge clock, single clock domain
//   rst_n        in   1          asynchronous, active-low reset
//   start        in   1          conversion request; sampled only in IDLE
//   signed_mode  in   1          1: bin is two's complement; 0: bin is unsigned
//   bin          in   WIDTH      value to convert (mux result Y)
//   busy         out  1          conversion in progress
//   done         out  1          one-cycle pulse: bcd/neg/zero just updated
//   bcd          out  DIGITS*4   digits; [3:0] units, [7:4] tens, [11:8] hundreds
//   neg          out  1          magnitude shown in bcd was negative
//   zero         out  1          converted value equals 0
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, busy=0, done=0, bcd=0, neg=0, zero=1,
//     shift counter=0, internal shift regs=0. Takes effect immediately, including
//     mid-conversion; the aborted conversion is discarded and outputs go to reset values.
//   FSM states: IDLE, SHIFT.
//   IDLE: if start=1 at edge k -> latch mag and sgn, clear BCD accumulator and
//     counter, go to SHIFT, busy=1 after edge k. If start=0, stay IDLE.
//     sgn = signed_mode & bin[WIDTH-1]; mag = sgn ? (~bin + 1) : bin (WIDTH bits,
//     so signed 8'h80 gives mag 128).
//   SHIFT: on each edge, every BCD nibble >= 5 gets +3 (combinational adjust),
//     then {accum, mag} shifts left by 1. Counter increments on each shift.
//   Shifts occur on edges k+1..k+8 (WIDTH shifts). On edge k+WIDTH:
//     - bcd is loaded with the adjusted and shifted accumulator.
//     - neg=sgn, zero=(mag_latched==0), done=1, busy=0, state=IDLE.
//   Latency: WIDTH cycles from the start-sampling edge to the done-asserted edge.
//   done clears on the next edge (k+WIDTH+1) unconditionally.
//   A new start can be sampled at edge k+WIDTH+1 at the earliest.
//   start while busy=1 is ignored, not queued; bin changes while busy have no effect.
//   bcd/neg/zero change only at the done edge or on reset; they hold between conversions.
//   neg=0 whenever magnitude is 0.
//   No illegal BCD: every output nibble is <= 9 for all inputs and both modes.
//   Unused FSM encodings recover to IDLE on the next edge.
// TESTING
//   1 unsigned bin=8'hFF, start pulse -> busy 8 cycles, done pulse, bcd=12'h255, neg=0, zero=0
//   2 signed_mode=1, bin=8'hFF -> bcd=12'h001, neg=1; bin=8'h80 -> bcd=12'h128, neg=1
//   3 bin=8'h00, both modes -> bcd=12'h000, zero=1, neg=0; unsigned 8'h7B -> 12'h123
//   4 start held high continuously with bin=8'd42 -> conversions back-to-back, one done
//     per 9 cycles, no start accepted while busy; changing bin mid-conversion leaves result 042
//   5 rst_n low at the 4th shift of 8'hC8 -> outputs reset immediately; after release,
//     new start with 8'd9 -> bcd=12'h009
//   6 exhaustive sweep 0..255 in both modes vs reference model: all nibbles <= 9, exact match

Source files
------------

// File: rtl/conversor_bin_bcd_8bits.sv
// -----------------------------------------------------------------------------
// conversor_bin_bcd_8bits
//
// Sequential binary-to-BCD converter using the shift-add-3 (double dabble)
// algorithm, one input bit per clock. It sits right after the ULA result mux.
// On a start request it captures the mux output, takes its magnitude when the
// value is two's complement and negative, and after WIDTH shift cycles it
// publishes the decimal digits together with sign and zero flags for the
// display decoders. The published result holds until the next conversion ends.
//
// Parameters
//   WIDTH        binary input width, and the number of shift cycles per
//                conversion
//   DIGITS       number of BCD digits produced (DIGITS*4 bits of output)
//
// Ports
//   clk          in   1          rising-edge clock
//   rst_n        in   1          asynchronous active-low reset
//   start        in   1          conversion request, only looked at in IDLE
//   signed_mode  in   1          1: bin is two's complement, 0: unsigned
//   bin          in   WIDTH      value to convert
//   busy         out  1          conversion in progress
//   done         out  1          one-cycle pulse, bcd/neg/zero just updated
//   bcd          out  DIGITS*4   [3:0] units, [7:4] tens, [11:8] hundreds
//   neg          out  1          the magnitude shown in bcd was negative
//   zero         out  1          converted value equals zero
// -----------------------------------------------------------------------------
module conversor_bin_bcd_8bits #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  signed_mode,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd,
    output logic                  neg,
    output logic                  zero
);

    localparam int               BCD_W    = DIGITS * 4;
    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Two spare encodings exist; the next-state default sends them to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mag_q, mag_d;          // magnitude, shifted out MSB first
    logic [BCD_W-1:0]   accum_q, accum_d;      // BCD accumulator under construction
    logic [CNT_W-1:0]   cnt_q, cnt_d;          // shifts already performed
    logic               sgn_q, sgn_d;          // sign of the captured value
    logic               mag_zero_q, mag_zero_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               neg_q, neg_d;
    logic               zero_q, zero_d;
    logic               done_q, done_d;

    // Capture-side decode of the incoming value.
    logic               in_sgn;
    logic [WIDTH-1:0]   in_mag;

    // Accumulator after the +3 correction, before the shift.
    logic [BCD_W-1:0]   accum_adj;
    logic [BCD_W-1:0]   accum_shift;

    // -------------------------------------------------------------------------
    // Input decode: negate only when the value is signed and negative. The
    // result is kept to WIDTH bits, so the most negative code maps onto its
    // own pattern, which read as unsigned is exactly the right magnitude.
    // -------------------------------------------------------------------------
    assign in_sgn = signed_mode & bin[WIDTH-1];
    assign in_mag = in_sgn ? ((~bin) + WIDTH'(1)) : bin;

    // -------------------------------------------------------------------------
    // Shift-add-3 correction: any digit >= 5 would become >= 10 after doubling,
    // so adding 3 first makes the doubling carry into the next digit.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written in an always_comb gets a default first;
        // a path that leaves one unassigned would infer a latch.
        accum_adj = accum_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (accum_q[d*4 +: 4] >= 4'd5) begin
                accum_adj[d*4 +: 4] = accum_q[d*4 +: 4] + 4'd3;
            end
        end
    end

    // The next magnitude bit enters the units digit from the right.
    assign accum_shift = {accum_adj[BCD_W-2:0], mag_q[WIDTH-1]};

    // -------------------------------------------------------------------------
    // Next-state and datapath control.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = IDLE;
        mag_d      = mag_q;
        accum_d    = accum_q;
        cnt_d      = cnt_q;
        sgn_d      = sgn_q;
        mag_zero_d = mag_zero_q;
        bcd_d      = bcd_q;
        neg_d      = neg_q;
        zero_d     = zero_q;
        done_d     = 1'b0;                    // pulse: cleared on every edge by default

        unique case (state_q)
            IDLE: begin
                state_d = IDLE;
                if (start) begin
                    mag_d      = in_mag;
                    sgn_d      = in_sgn;
                    mag_zero_d = (in_mag == '0);
                    accum_d    = '0;
                    cnt_d      = '0;
                    state_d    = SHIFT;
                end
            end

            SHIFT: begin
                accum_d = accum_shift;
                mag_d   = {mag_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = SHIFT;
                if (cnt_q == CNT_LAST) begin
                    // Last shift: publish the finished digits straight from
                    // the shift path rather than waiting another cycle.
                    bcd_d   = accum_shift;
                    neg_d   = sgn_q & ~mag_zero_q;
                    zero_d  = mag_zero_q;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers. Reset aborts any conversion in flight and puts every
    // output back to its idle value at once.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mag_q      <= '0;
            accum_q    <= '0;
            cnt_q      <= '0;
            sgn_q      <= 1'b0;
            mag_zero_q <= 1'b1;
            bcd_q      <= '0;
            neg_q      <= 1'b0;
            zero_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the values from before this edge, independent of statement order.
            state_q    <= state_d;
            mag_q      <= mag_d;
            accum_q    <= accum_d;
            cnt_q      <= cnt_d;
            sgn_q      <= sgn_d;
            mag_zero_q <= mag_zero_d;
            bcd_q      <= bcd_d;
            neg_q      <= neg_d;
            zero_q     <= zero_d;
            done_q     <= done_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign bcd  = bcd_q;
    assign neg  = neg_q;
    assign zero = zero_q;

endmodule
